wir_ctrl: RTL

IEEE 1500 wrapper instruction register (WIR) controller: the initiating end of the wrapper control bus that the wrapped EX core consumes.
- Shifts instructions in serially on WSI and captures a fixed pattern.
- Latches the decoded instruction on UpdateWR.
- Drives the static mode bits (wir_extest, wir_wpc, wir_wbr_concat, scanmode, ...) and the per-cycle shift strobes (wse_inputs, wse_outputs, wby_shift, se).
- Hosts the 1-bit wrapper bypass register (WBY).
- Selects the WSO source.

---
 rtl/wir_pkg.sv | 40 ++++
 rtl/wir_if.sv | 50 +++++
 rtl/wir_decode.sv | 50 +++++
 rtl/wir_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/wir_pkg.sv
// Shared definitions for the IEEE 1500 wrapper instruction register controller:
// register width, opcode values, capture pattern and decoded mode bundle.
package wir_pkg;

  localparam int WIR_W = 4;

  localparam logic [3:0] WS_BYPASS = 4'h0;
  localparam logic [3:0] WS_EXTEST = 4'h1;
  localparam logic [3:0] WS_INTEST = 4'h2;
  localparam logic [3:0] WS_SCAN   = 4'h3;
  localparam logic [3:0] WP_EXTEST = 4'h4;
  localparam logic [3:0] WP_BYPASS = 4'h5;
  localparam logic [3:0] WS_MBIST  = 4'h6;
  localparam logic [3:0] WS_CLAMP  = 4'h7;

  // Fixed value loaded into the shift stage on CaptureWR.
  localparam logic [3:0] WIR_CAPTURE = 4'b0001;

  // Static mode bits driven towards the wrapped core.
  typedef struct packed {
    logic wirExtest;
    logic extest;
    logic wirWpc;
    logic wirWbrConcat;
    logic wbrConcat;
    logic scanmode;
    logic mbistmode;
    logic busDisable;
    logic wppBypass;
    logic holdInputs;
    logic holdOutputs;
  } wirModes_t;

  // Instructions whose data path goes serially through the WBR; everything
  // else, reserved codes included, routes data through the bypass bit.
  function automatic logic isSerialWbr(input logic [3:0] op);
    return (op == WS_EXTEST) || (op == WS_INTEST) || (op == WS_SCAN);
  endfunction

endpackage

// File: rtl/wir_if.sv
// Wrapper serial port bundle between the WIR controller and its environment.
// master is the controller side, slave is the side driving WSP strobes.
interface wir_if;

  logic WSI;
  logic wbr_so;
  logic WSO;
  logic SelectWIR;
  logic CaptureWR;
  logic ShiftWR;
  logic UpdateWR;

  logic wir_extest;
  logic extest;
  logic wir_wpc;
  logic wir_wbr_concat;
  logic wbr_concat;
  logic scanmode;
  logic mbistmode;
  logic bus_disable;
  logic wpp_bypass;
  logic hold_inputs;
  logic hold_outputs;

  logic wse_inputs;
  logic wse_outputs;
  logic se;
  logic wby_shift;

  logic wir_illegal;

  modport master (
    input  WSI, wbr_so, SelectWIR, CaptureWR, ShiftWR, UpdateWR,
    output WSO,
    output wir_extest, extest, wir_wpc, wir_wbr_concat, wbr_concat,
    output scanmode, mbistmode, bus_disable, wpp_bypass, hold_inputs, hold_outputs,
    output wse_inputs, wse_outputs, se, wby_shift,
    output wir_illegal
  );

  modport slave (
    output WSI, wbr_so, SelectWIR, CaptureWR, ShiftWR, UpdateWR,
    input  WSO,
    input  wir_extest, extest, wir_wpc, wir_wbr_concat, wbr_concat,
    input  scanmode, mbistmode, bus_disable, wpp_bypass, hold_inputs, hold_outputs,
    input  wse_inputs, wse_outputs, se, wby_shift,
    input  wir_illegal
  );

endinterface

// File: rtl/wir_decode.sv
// Combinational instruction decoder: opcode -> mode bits, reserved flag and
// serial-WBR flag. Reserved codes behave as WS_BYPASS but raise illegal.
module wir_decode
  import wir_pkg::*;
(
  input  logic [3:0] i_wirUp,
  output wirModes_t  o_modes,
  output logic       o_illegal,
  output logic       o_serialWbr
);

  // Map each opcode to the set of mode bits it asserts; all others stay low.
  always_comb begin
    o_modes   = '0;
    o_illegal = 1'b0;
    case (i_wirUp)
      WS_BYPASS: ;
      WS_EXTEST: begin
        o_modes.wirExtest  = 1'b1;
        o_modes.extest     = 1'b1;
        o_modes.holdInputs = 1'b1;
      end
      WS_INTEST: o_modes.holdOutputs = 1'b1;
      WS_SCAN: begin
        o_modes.scanmode     = 1'b1;
        o_modes.wbrConcat    = 1'b1;
        o_modes.wirWbrConcat = 1'b1;
      end
      WP_EXTEST: begin
        o_modes.wirExtest = 1'b1;
        o_modes.extest    = 1'b1;
        o_modes.wirWpc    = 1'b1;
      end
      WP_BYPASS: o_modes.wppBypass = 1'b1;
      WS_MBIST: begin
        o_modes.mbistmode   = 1'b1;
        o_modes.holdOutputs = 1'b1;
      end
      WS_CLAMP: begin
        o_modes.busDisable  = 1'b1;
        o_modes.holdInputs  = 1'b1;
        o_modes.holdOutputs = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase
  end

  assign o_serialWbr = isSerialWbr(i_wirUp);

endmodule

// File: rtl/wir_ctrl.sv
// IEEE 1500 WIR controller: shift/update instruction stages, bypass bit,
// registered mode outputs, per-cycle shift strobes and the WSO select.
module wir_ctrl #(
  parameter int WIR_W = wir_pkg::WIR_W
) (
  input logic   WRCK,
  input logic   RESET,
  wir_if.master bus
);

  import wir_pkg::*;

  logic [WIR_W-1:0] r_wirSh;
  logic [WIR_W-1:0] r_wirUp;
  logic             r_wby;
  logic             r_serialWbr;
  logic             r_illegal;
  wirModes_t        r_modes;

  logic [WIR_W-1:0] w_wirUpNext;
  wirModes_t        w_decModes;
  logic             w_decIllegal;
  logic             w_decSerialWbr;
  logic             w_capWir;
  logic             w_shiftWir;
  logic             w_updWir;
  logic             w_dshift;
  logic             w_wbyEn;

  // Capture beats shift beats update when strobes collide.
  assign w_capWir    = bus.CaptureWR & bus.SelectWIR;
  assign w_shiftWir  = bus.ShiftWR & bus.SelectWIR & ~bus.CaptureWR;
  assign w_updWir    = bus.UpdateWR & bus.SelectWIR & ~bus.CaptureWR & ~bus.ShiftWR;
  assign w_wirUpNext = w_updWir ? r_wirSh : r_wirUp;
  assign w_wbyEn     = ~bus.SelectWIR & ~r_serialWbr;

  // Decoding the next update value lets mode flops change on the update edge.
  wir_decode u_decode (
    .i_wirUp     (w_wirUpNext),
    .o_modes     (w_decModes),
    .o_illegal   (w_decIllegal),
    .o_serialWbr (w_decSerialWbr)
  );

  // Instruction shift stage: capture the fixed pattern or shift in WSI LSB-first.
  always_ff @(posedge WRCK) begin
    if (RESET) begin
      r_wirSh <= '0;
    end else if (w_capWir) begin
      r_wirSh <= WIR_CAPTURE;
    end else if (w_shiftWir) begin
      r_wirSh <= {bus.WSI, r_wirSh[WIR_W-1:1]};
    end
  end

  // Instruction update stage plus the registered decode that follows it.
  always_ff @(posedge WRCK) begin
    if (RESET) begin
      r_wirUp     <= '0;
      r_modes     <= '0;
      r_illegal   <= 1'b0;
      r_serialWbr <= 1'b0;
    end else begin
      r_wirUp     <= w_wirUpNext;
      r_modes     <= w_decModes;
      r_illegal   <= w_decIllegal;
      r_serialWbr <= w_decSerialWbr;
    end
  end

  // Single-bit wrapper bypass register, active only for bypass-class instructions.
  always_ff @(posedge WRCK) begin
    if (RESET) begin
      r_wby <= 1'b0;
    end else if (w_wbyEn) begin
      if (bus.CaptureWR) begin
        r_wby <= 1'b0;
      end else if (bus.ShiftWR) begin
        r_wby <= bus.WSI;
      end
    end
  end

  assign w_dshift = bus.ShiftWR & ~bus.SelectWIR;

  assign bus.wse_inputs  = w_dshift & r_serialWbr;
  assign bus.wse_outputs = w_dshift & r_serialWbr;
  assign bus.se          = w_dshift & (r_wirUp == WS_SCAN);
  assign bus.wby_shift   = w_dshift & ~r_serialWbr;

  assign bus.WSO = bus.SelectWIR ? r_wirSh[0] : (r_serialWbr ? bus.wbr_so : r_wby);

  assign bus.wir_extest     = r_modes.wirExtest;
  assign bus.extest         = r_modes.extest;
  assign bus.wir_wpc        = r_modes.wirWpc;
  assign bus.wir_wbr_concat = r_modes.wirWbrConcat;
  assign bus.wbr_concat     = r_modes.wbrConcat;
  assign bus.scanmode       = r_modes.scanmode;
  assign bus.mbistmode      = r_modes.mbistmode;
  assign bus.bus_disable    = r_modes.busDisable;
  assign bus.wpp_bypass     = r_modes.wppBypass;
  assign bus.hold_inputs    = r_modes.holdInputs;
  assign bus.hold_outputs   = r_modes.holdOutputs;
  assign bus.wir_illegal    = r_illegal;

endmodule
